// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller:
// FSM state encoding and the pipeline stall vectors it drives.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    FRC_BOOT = 2'd0,
    FRC_RUN  = 2'd1,
    FRC_PEND = 2'd2
  } frc_state_e;

  // Bit order is [0]PC [1]IF [2]ID [3]EX [4]MEM; 1 = hold that stage
  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_IBUS = 5'b00011;
  localparam logic [4:0] STALL_ID   = 5'b00111;
  localparam logic [4:0] STALL_EX   = 5'b01111;
  localparam logic [4:0] STALL_MEM  = 5'b11111;

  // The deepest stalling stage wins; it freezes everything upstream of it
  function automatic logic [4:0] stall_vector(input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem,
                                              input logic hold_fetch);
    logic [4:0] vec;
    if (req_mem)         vec = STALL_MEM;
    else if (req_ex)     vec = STALL_EX;
    else if (req_id)     vec = STALL_ID;
    else if (hold_fetch) vec = STALL_IBUS;
    else                 vec = STALL_NONE;
    return vec;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// PC sequencing: boot delay before fetch, stall vector generation, and
// trap-over-branch redirect arbitration with a pending slot for a busy ibus.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int BOOT_DELAY = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              ibus_busy_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              branch_req_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              pc_ce_o,
  output logic [4:0]        stalled_o,
  output logic              branch_flag_o,
  output logic [ADDR_W-1:0] branch_addr_o,
  output logic              flush_o
);

  localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DELAY - 1);

  frc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] last_q;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] req_addr;

  assign req_addr = trap_req_i ? trap_addr_i : branch_addr_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FRC_BOOT;
      cnt_q   <= '0;
      pend_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (issue) last_q <= issue_addr;
    end
  end

  // issue_addr defaults to the last issued target so branch_addr_o holds when idle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    issue      = 1'b0;
    issue_addr = last_q;
    case (state_q)
      FRC_BOOT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BOOT_LAST) begin
          state_d = FRC_RUN;
          cnt_d   = '0;
        end
      end
      FRC_RUN: begin
        if (trap_req_i || branch_req_i) begin
          if (!ibus_busy_i) begin
            issue      = 1'b1;
            issue_addr = req_addr;
          end else begin
            pend_d  = req_addr;
            state_d = FRC_PEND;
          end
        end
      end
      FRC_PEND: begin
        // Branches arriving here are on the wrong path; only traps can replace the pending target
        if (!ibus_busy_i) begin
          issue      = 1'b1;
          issue_addr = trap_req_i ? trap_addr_i : pend_q;
          state_d    = FRC_RUN;
        end else if (trap_req_i) begin
          pend_d = trap_addr_i;
        end
      end
      default: state_d = FRC_BOOT;
    endcase
  end

  assign pc_ce_o       = (state_q != FRC_BOOT);
  assign stalled_o     = stall_vector(stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
                                      ibus_busy_i || (state_q == FRC_PEND));
  assign branch_flag_o = issue;
  assign flush_o       = issue;
  assign branch_addr_o = issue_addr;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: stimulus queues expected redirects,
// a negedge monitor pops them whenever the DUT raises branch_flag_o.
module tb_fetch_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        ibus_busy_i;
  logic        trap_req_i;
  logic [31:0] trap_addr_i;
  logic        branch_req_i;
  logic [31:0] branch_addr_i;
  logic        pc_ce_o;
  logic [4:0]  stalled_o;
  logic        branch_flag_o;
  logic [31:0] branch_addr_o;
  logic        flush_o;

  fetch_redirect_ctrl #(.BOOT_DELAY(4), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .stallreq_mem_i(stallreq_mem_i),
    .ibus_busy_i   (ibus_busy_i),
    .trap_req_i    (trap_req_i),
    .trap_addr_i   (trap_addr_i),
    .branch_req_i  (branch_req_i),
    .branch_addr_i (branch_addr_i),
    .pc_ce_o       (pc_ce_o),
    .stalled_o     (stalled_o),
    .branch_flag_o (branch_flag_o),
    .branch_addr_o (branch_addr_o),
    .flush_o       (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // Per-cycle check requests, set by stimulus after a posedge, consumed at the negedge
  logic        chk_rst, chk_pce, chk_stall, chk_addr, chk_fin;
  logic        exp_pce;
  logic [4:0]  exp_stall;
  logic [31:0] exp_addr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] want;
    if (chk_rst)
      checkOutput("reset_outputs",
                  {24'd0, pc_ce_o, stalled_o, branch_flag_o, flush_o} | branch_addr_o, 32'd0);
    if (chk_pce)   checkOutput("pc_ce", {31'd0, pc_ce_o}, {31'd0, exp_pce});
    if (chk_stall) checkOutput("stalled", {27'd0, stalled_o}, {27'd0, exp_stall});
    if (chk_addr)  checkOutput("addr_hold", branch_addr_o, exp_addr);
    if (branch_flag_o || flush_o) begin
      checkOutput("flush_with_flag", {31'd0, flush_o}, {31'd0, branch_flag_o});
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_redirect", branch_addr_o, 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        checkOutput("redirect_addr", branch_addr_o, want);
      end
    end
    if (chk_fin) checkOutput("missing_redirects", exp_q.size(), 0);
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
    chk_rst = 0; chk_pce = 0; chk_stall = 0; chk_addr = 0; chk_fin = 0;
  endtask

  task automatic applyStimulus(input logic id, input logic ex, input logic mem, input logic busy,
                               input logic trap, input logic [31:0] ta,
                               input logic br, input logic [31:0] ba);
    stallreq_id_i  = id;
    stallreq_ex_i  = ex;
    stallreq_mem_i = mem;
    ibus_busy_i    = busy;
    trap_req_i     = trap;
    trap_addr_i    = ta;
    branch_req_i   = br;
    branch_addr_i  = ba;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic expectStall(input logic [4:0] v);
    chk_stall = 1; exp_stall = v;
  endtask

  task automatic expectHold(input logic [31:0] a);
    chk_addr = 1; exp_addr = a;
  endtask

  task automatic bootCheck(input int delay);
    for (int i = 0; i <= delay; i++) begin
      chk_pce = 1; exp_pce = (i >= delay);
      expectStall(5'b00000);
      // A redirect during boot must be ignored
      if (i == 1) applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_0000, 1, 32'hBEEF_0000);
      else idle();
      if (i < delay) nextCycle();
    end
  endtask

  initial begin
    chk_rst = 0; chk_pce = 0; chk_stall = 0; chk_addr = 0; chk_fin = 0;
    exp_pce = 0; exp_stall = 0; exp_addr = 0;
    rst = 1'b0;
    idle();
    nextCycle(); chk_rst = 1;
    nextCycle(); chk_rst = 1;
    nextCycle();

    $display("[TB] boot sequence");
    rst = 1'b1;
    bootCheck(4);

    $display("[TB] branch with idle bus");
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h0000_0100); exp_q.push_back(32'h0000_0100);
    nextCycle(); idle(); expectHold(32'h0000_0100);

    $display("[TB] trap beats branch");
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0004, 1, 32'h0000_0200); exp_q.push_back(32'h0000_0004);
    nextCycle(); idle(); expectHold(32'h0000_0004);

    $display("[TB] branch held pending on busy bus");
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h0000_0300); expectStall(5'b00011);
    nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h0000_0999); expectStall(5'b00011);
    nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0); expectStall(5'b00011);
    nextCycle(); idle(); expectStall(5'b00011); exp_q.push_back(32'h0000_0300);
    nextCycle(); idle(); expectStall(5'b00000); expectHold(32'h0000_0300);

    $display("[TB] trap overwrites pending branch");
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h0000_0340);
    nextCycle(); applyStimulus(0, 0, 0, 1, 1, 32'h0000_0008, 0, 32'h0);
    nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    nextCycle(); idle(); exp_q.push_back(32'h0000_0008);
    nextCycle(); idle(); expectHold(32'h0000_0008);

    $display("[TB] trap on the release cycle wins");
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h0000_0500);
    nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 1, 32'h0000_000C, 0, 32'h0); exp_q.push_back(32'h0000_000C);
    nextCycle(); idle(); expectHold(32'h0000_000C);

    $display("[TB] stall priority");
    nextCycle(); applyStimulus(1, 0, 1, 0, 0, 32'h0, 0, 32'h0); expectStall(5'b11111);
    nextCycle(); applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 32'h0); expectStall(5'b01111);
    nextCycle(); applyStimulus(1, 0, 0, 0, 0, 32'h0, 0, 32'h0); expectStall(5'b00111);
    nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0); expectStall(5'b00011);
    nextCycle(); applyStimulus(1, 1, 1, 1, 0, 32'h0, 0, 32'h0); expectStall(5'b11111);
    nextCycle(); applyStimulus(0, 1, 0, 0, 0, 32'h0, 1, 32'h0000_0600);
    expectStall(5'b01111); exp_q.push_back(32'h0000_0600);
    nextCycle(); idle(); expectHold(32'h0000_0600);

    $display("[TB] reset while pending");
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h0000_0700);
    nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0); expectStall(5'b00011);
    nextCycle(); idle(); rst = 1'b0; chk_rst = 1;
    nextCycle(); chk_rst = 1;
    nextCycle();
    rst = 1'b1;
    bootCheck(4);
    for (int i = 0; i < 4; i++) begin
      nextCycle(); idle(); expectHold(32'h0); chk_pce = 1; exp_pce = 1;
    end

    nextCycle(); chk_fin = 1;
    nextCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
